// File: rtl/rc_pwm_decoder.sv
// Servo PWM receiver: measures the high time of each pulse, classifies it into a
// CW/STOP/CCW command and flags glitches, over-length pulses and loss of signal.
module rc_pwm_decoder #(
  parameter int unsigned MIN_PULSE = 6000,
  parameter int unsigned MAX_PULSE = 30000,
  parameter int unsigned CENTER    = 18000,
  parameter int unsigned DEADBAND  = 600,
  parameter int unsigned TIMEOUT   = 360000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [14:0] pulse_width,
  output logic        pulse_valid,
  output logic [1:0]  speed_cmd,
  output logic        signal_lost,
  output logic        pulse_err
);

  localparam logic [1:0] ST_ARM   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_WLOW  = 2'd3;

  localparam logic [14:0] MIN_W    = 15'(MIN_PULSE);
  localparam logic [14:0] MAX_W    = 15'(MAX_PULSE);
  localparam logic [14:0] CENTER_W = 15'(CENTER);
  localparam logic [18:0] TO_LIM   = 19'(TIMEOUT);
  localparam logic [15:0] LO_BND   = 16'(CENTER - DEADBAND);
  localparam logic [15:0] HI_BND   = 16'(CENTER + DEADBAND);

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_CW   = 2'b01;
  localparam logic [1:0] CMD_CCW  = 2'b10;

  function automatic logic [1:0] classify(input logic [14:0] w);
    logic [15:0] w16;
    w16 = {1'b0, w};
    if (w16 < LO_BND)      classify = CMD_CW;
    else if (w16 > HI_BND) classify = CMD_CCW;
    else                   classify = CMD_STOP;
  endfunction

  logic        sync1_q, s_q, sd_q;
  logic        rise, fall;
  logic [1:0]  state_q, state_d;
  logic [14:0] hi_cnt_q, hi_cnt_d;
  logic [18:0] to_cnt_q, to_cnt_d;
  logic [14:0] width_q, width_d;
  logic [1:0]  spd_q, spd_d;
  logic        vld_q, vld_d;
  logic        lost_q, lost_d;
  logic        err_q, err_d;

  // Synchronizer idles high so a pin already high at reset release is not seen as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
      sd_q    <= 1'b1;
    end else begin
      sync1_q <= pwm_in;
      s_q     <= sync1_q;
      sd_q    <= s_q;
    end
  end

  assign rise = s_q & ~sd_q;
  assign fall = ~s_q & sd_q;

  always_comb begin
    state_d  = state_q;
    hi_cnt_d = hi_cnt_q;
    to_cnt_d = (to_cnt_q == TO_LIM) ? to_cnt_q : to_cnt_q + 19'd1;
    width_d  = width_q;
    spd_d    = spd_q;
    lost_d   = lost_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_ARM: begin
        if (!s_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rise) begin
          hi_cnt_d = 15'd1;
          to_cnt_d = '0;
          state_d  = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          if (hi_cnt_q >= MIN_W && hi_cnt_q <= MAX_W) begin
            width_d = hi_cnt_q;
            spd_d   = classify(hi_cnt_q);
            vld_d   = 1'b1;
            lost_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (hi_cnt_q == MAX_W) begin
          err_d   = 1'b1;
          state_d = ST_WLOW;
        end else begin
          hi_cnt_d = hi_cnt_q + 15'd1;
        end
      end
      default: begin
        if (!s_q) state_d = ST_IDLE;
      end
    endcase

    // Timeout only takes effect when no pulse is being accepted in the same cycle.
    if (to_cnt_d == TO_LIM && to_cnt_q != TO_LIM && !vld_d) begin
      lost_d  = 1'b1;
      spd_d   = CMD_STOP;
      width_d = CENTER_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ARM;
      hi_cnt_q <= '0;
      to_cnt_q <= '0;
      width_q  <= CENTER_W;
      spd_q    <= CMD_STOP;
      vld_q    <= 1'b0;
      lost_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_cnt_q <= hi_cnt_d;
      to_cnt_q <= to_cnt_d;
      width_q  <= width_d;
      spd_q    <= spd_d;
      vld_q    <= vld_d;
      lost_q   <= lost_d;
      err_q    <= err_d;
    end
  end

  assign pulse_width = width_q;
  assign pulse_valid = vld_q;
  assign speed_cmd   = spd_q;
  assign signal_lost = lost_q;
  assign pulse_err   = err_q;

endmodule

// File: tb/tb_rc_pwm_decoder.sv
// Scoreboard bench for rc_pwm_decoder with timing parameters scaled down by 100.
module tb_rc_pwm_decoder;

  localparam int MIN_P = 60;
  localparam int MAX_P = 300;
  localparam int CTR   = 180;
  localparam int DB    = 6;
  localparam int TO    = 3600;

  localparam int K_VALID = 0;
  localparam int K_ERR   = 1;
  localparam int K_LOST  = 2;

  typedef struct {
    int kind;
    int width;
    int spd;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [14:0] pulse_width;
  logic        pulse_valid;
  logic [1:0]  speed_cmd;
  logic        signal_lost;
  logic        pulse_err;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cur_w = CTR;
  int   cur_spd = 0;
  logic prev_lost = 1'b1;

  rc_pwm_decoder #(
    .MIN_PULSE(MIN_P), .MAX_PULSE(MAX_P), .CENTER(CTR), .DEADBAND(DB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .pulse_width(pulse_width), .pulse_valid(pulse_valid), .speed_cmd(speed_cmd),
    .signal_lost(signal_lost), .pulse_err(pulse_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive an n-cycle high pulse followed by gap low cycles; record the expected event.
  task automatic pulse(input int n, input bit ok, input int spd, input int gap, output int p);
    exp_t e;
    p = cyc;
    pwm_in = 1'b1;
    if (ok) begin
      e = '{kind: K_VALID, width: n, spd: spd, cyc: 0};
      cur_w = n;
      cur_spd = spd;
    end else begin
      e = '{kind: K_ERR, width: cur_w, spd: cur_spd, cyc: 0};
    end
    q.push_back(e);
    repeat (n) @(negedge clk);
    pwm_in = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_lost = 1'b1;
    end else begin
      if (pulse_valid && pulse_err) chk("valid_err_overlap", 1, 0);
      if (pulse_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("valid_kind", K_VALID, e.kind);
          chk("valid_width", int'(pulse_width), e.width);
          chk("valid_speed", int'(speed_cmd), e.spd);
          chk("valid_lost_clear", int'(signal_lost), 0);
        end
      end
      if (pulse_err) begin
        if (q.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          e = q.pop_front();
          chk("err_kind", K_ERR, e.kind);
          chk("err_width_held", int'(pulse_width), e.width);
          chk("err_speed_held", int'(speed_cmd), e.spd);
        end
      end
      if (signal_lost && !prev_lost) begin
        if (q.size() == 0) chk("unexpected_lost", 1, 0);
        else begin
          e = q.pop_front();
          chk("lost_kind", K_LOST, e.kind);
          chk("lost_cycle", cyc, e.cyc);
          chk("lost_width", int'(pulse_width), CTR);
          chk("lost_speed", int'(speed_cmd), 0);
        end
      end
      prev_lost = signal_lost;
    end
  end

  initial begin
    int p;
    exp_t e;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_lost", int'(signal_lost), 1);
    chk("rst_width", int'(pulse_width), CTR);
    chk("rst_speed", int'(speed_cmd), 0);
    chk("rst_valid", int'(pulse_valid), 0);
    chk("rst_err", int'(pulse_err), 0);

    // Frames of 120 (CW) then 240 (CCW) with 2400-cycle period.
    pulse(120, 1'b1, 1, 2280, p);
    pulse(120, 1'b1, 1, 2280, p);
    pulse(240, 1'b1, 2, 2160, p);
    pulse(240, 1'b1, 2, 2160, p);

    // Deadband edges: 174 and 186 are inside the STOP band.
    pulse(173, 1'b1, 1, 300, p);
    pulse(174, 1'b1, 0, 300, p);
    pulse(186, 1'b1, 0, 300, p);
    pulse(187, 1'b1, 2, 300, p);

    // Rejections and acceptance limits.
    pulse(10,  1'b0, 0, 300, p);
    pulse(59,  1'b0, 0, 300, p);
    pulse(60,  1'b1, 1, 300, p);
    pulse(300, 1'b1, 2, 300, p);
    pulse(301, 1'b0, 0, 300, p);
    pulse(120, 1'b1, 1, 300, p);

    // Loss of signal: lost must rise TO cycles after the accepted rise (3 cycles after drive).
    pulse(120, 1'b1, 1, 0, p);
    e = '{kind: K_LOST, width: CTR, spd: 0, cyc: p + 3 + TO};
    q.push_back(e);
    repeat (TO + 100) @(negedge clk);
    cur_w = CTR;
    cur_spd = 0;
    chk("lost_held", int'(signal_lost), 1);
    pulse(240, 1'b1, 2, 300, p);

    // Reset in the middle of a pulse, released while the pin is still high.
    pwm_in = 1'b1;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_width", int'(pulse_width), CTR);
    chk("midrst_lost", int'(signal_lost), 1);
    rst_n = 1'b1;
    cur_w = CTR;
    cur_spd = 0;
    repeat (50) @(negedge clk);
    pwm_in = 1'b0;
    repeat (300) @(negedge clk);
    chk("midrst_after_width", int'(pulse_width), CTR);
    pulse(120, 1'b1, 1, 300, p);

    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
